// File: rtl/rx_queue_aur.sv
// rx_queue_aur: receive queue for the Aurora LocalLink RX stream.
// Packs 16-bit halfwords into 64-bit pipeline words with last-byte ctrl,
// buffers whole packets and releases them only once committed. The link has
// no backpressure, so packets that cannot fit are dropped whole.
module rx_queue_aur #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH/8,
  parameter int ADDR_WIDTH    = 9,
  parameter int MAX_PKT_WORDS = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           aur_rx_d,
  input  logic                  aur_rx_src_rdy_n,
  input  logic                  aur_rx_sof_n,
  input  logic                  aur_rx_eof_n,
  input  logic                  aur_rx_rem,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  pkt_rcvd,
  output logic                  pkt_dropped,
  output logic                  pkt_err
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int RAM_W = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_WIDTH);
  localparam logic [PW-1:0] MAX_W = PW'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_DROP
  } state_t;

  state_t                r_state;
  logic [1:0]            r_lane;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_commit_ptr;
  logic [PW-1:0]         r_rd_ptr;

  logic [RAM_W-1:0]      r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                  w_accept;
  logic                  w_sof;
  logic                  w_eof;
  logic [PW-1:0]         w_used;
  logic [PW-1:0]         w_free;
  logic [PW-1:0]         w_free_adm;
  logic [PW-1:0]         w_pkt_words;
  logic                  w_admit;
  logic                  w_in_pkt;
  logic                  w_too_long;
  logic                  w_take;
  logic [1:0]            w_lane;
  logic [DATA_WIDTH-1:0] w_asm;
  logic [CTRL_WIDTH-1:0] w_ctrl;
  logic                  w_we;
  logic [PW-1:0]         w_wr_base;
  logic                  w_rd_en;

  assign w_accept = ~aur_rx_src_rdy_n;
  assign w_sof    = w_accept & ~aur_rx_sof_n;
  assign w_eof    = w_accept & ~aur_rx_eof_n;

  // Occupancy counts everything written so far, including a partial packet.
  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_free = DEPTH - w_used;

  // A SOF arriving in RX rolls the partial packet back first, so the
  // admission check must see the space that the rollback frees.
  assign w_free_adm = (r_state == S_RX) ? (DEPTH - (r_commit_ptr - r_rd_ptr)) : w_free;

  // Completed words of the packet currently being assembled.
  assign w_pkt_words = r_wr_ptr - r_commit_ptr;

  // Decide what the current halfword does and build the word it belongs to.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    w_admit    = 1'b0;
    w_in_pkt   = 1'b0;
    w_too_long = 1'b0;
    w_take     = 1'b0;
    w_lane     = r_lane;
    w_asm      = '0;
    w_ctrl     = '0;
    w_we       = 1'b0;
    w_wr_base  = r_wr_ptr;

    w_admit    = w_sof & (w_free_adm >= MAX_W);
    w_in_pkt   = w_accept & aur_rx_sof_n & (r_state == S_RX);
    w_too_long = w_in_pkt & (r_lane == 2'd0) & (w_pkt_words == MAX_W);
    w_take     = w_admit | (w_in_pkt & ~w_too_long);

    if (w_admit) begin
      w_lane    = 2'd0;
      w_wr_base = r_commit_ptr;
    end

    // Lane 0 starts from a clean word so unused trailing lanes stay zero.
    w_asm = ((w_lane == 2'd0) ? '0 : r_asm) | ({aur_rx_d, 48'h0} >> {w_lane, 4'b0000});

    if (w_eof)
      w_ctrl = 8'h80 >> {w_lane, aur_rx_rem};

    w_we = w_take & ((w_lane == 2'd3) | w_eof);
  end

  // Packet buffer storage; the write uses the freshly assembled word.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; pointers alone define valid contents.
    if (w_we)
      r_mem[w_wr_base[ADDR_WIDTH-1:0]] <= {w_ctrl, w_asm};
  end

  // Write-side FSM: admission, packing, commit, rollback and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lane       <= 2'd0;
      r_asm        <= '0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      pkt_rcvd     <= 1'b0;
      pkt_dropped  <= 1'b0;
      pkt_err      <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read in this block sees pre-edge values.
      pkt_rcvd    <= 1'b0;
      pkt_dropped <= 1'b0;
      pkt_err     <= 1'b0;

      if (w_sof) begin
        // A SOF while a packet is open is a framing error; the old packet is discarded.
        if (r_state == S_RX)
          pkt_err <= 1'b1;
        if (w_admit) begin
          r_asm <= w_asm;
          if (w_eof) begin
            r_wr_ptr     <= r_commit_ptr + 1'b1;
            r_commit_ptr <= r_commit_ptr + 1'b1;
            pkt_rcvd     <= 1'b1;
            r_lane       <= 2'd0;
            r_state      <= S_IDLE;
          end else begin
            r_wr_ptr <= r_commit_ptr;
            r_lane   <= 2'd1;
            r_state  <= S_RX;
          end
        end else begin
          r_wr_ptr    <= r_commit_ptr;
          pkt_dropped <= 1'b1;
          r_lane      <= 2'd0;
          r_state     <= w_eof ? S_IDLE : S_DROP;
        end
      end else if (w_accept) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_eof)
              pkt_err <= 1'b1;
          end
          S_RX: begin
            if (w_too_long) begin
              r_wr_ptr    <= r_commit_ptr;
              pkt_dropped <= 1'b1;
              r_lane      <= 2'd0;
              r_state     <= w_eof ? S_IDLE : S_DROP;
            end else begin
              r_asm <= w_asm;
              if (w_eof) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_commit_ptr <= r_wr_ptr + 1'b1;
                pkt_rcvd     <= 1'b1;
                r_lane       <= 2'd0;
                r_state      <= S_IDLE;
              end else begin
                if (r_lane == 2'd3)
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                r_lane <= r_lane + 1'b1;
              end
            end
          end
          S_DROP: begin
            if (w_eof)
              r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Only committed words are eligible for reading; out_rdy is sampled at issue.
  assign w_rd_en = out_rdy & (r_rd_ptr != r_commit_ptr);

  // Read side: one-cycle RAM read into the registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= w_rd_en;
      if (w_rd_en) begin
        {out_ctrl, out_data} <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        r_rd_ptr             <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_queue_aur.sv
// tb_rx_queue_aur: directed stimulus for rx_queue_aur with a scoreboard.
// Stimulus pushes expected output words; a negedge monitor pops and compares.
module tb_rx_queue_aur;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] aur_rx_d;
  logic        aur_rx_src_rdy_n;
  logic        aur_rx_sof_n;
  logic        aur_rx_eof_n;
  logic        aur_rx_rem;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        pkt_rcvd;
  logic        pkt_dropped;
  logic        pkt_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int eof_cyc  = 0;
  bit lat_arm  = 1'b0;
  int n_rcvd   = 0;
  int n_drop   = 0;
  int n_err    = 0;
  int exp_rcvd = 0;
  int exp_drop = 0;
  int exp_err  = 0;

  logic [71:0] sb[$];
  logic [71:0] mon_exp;

  rx_queue_aur dut (
    .clk              (clk),
    .reset            (reset),
    .aur_rx_d         (aur_rx_d),
    .aur_rx_src_rdy_n (aur_rx_src_rdy_n),
    .aur_rx_sof_n     (aur_rx_sof_n),
    .aur_rx_eof_n     (aur_rx_eof_n),
    .aur_rx_rem       (aur_rx_rem),
    .out_data         (out_data),
    .out_ctrl         (out_ctrl),
    .out_wr           (out_wr),
    .out_rdy          (out_rdy),
    .pkt_rcvd         (pkt_rcvd),
    .pkt_dropped      (pkt_dropped),
    .pkt_err          (pkt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count status pulses and compare every output word to the scoreboard.
  always @(negedge clk) begin
    if (pkt_rcvd === 1'b1)    n_rcvd++;
    if (pkt_dropped === 1'b1) n_drop++;
    if (pkt_err === 1'b1)     n_err++;
    if (out_wr === 1'b1) begin
      if (lat_arm) begin
        check("first_out_latency", 72'(cyc - eof_cyc), 72'd2);
        lat_arm = 1'b0;
      end
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %h expected none", {out_ctrl, out_data});
      end else begin
        mon_exp = sb.pop_front();
        check("out_word", {out_ctrl, out_data}, mon_exp);
      end
    end
  end

  task automatic hw(input logic [15:0] d, input bit sof, input bit eof, input bit r);
    @(posedge clk);
    #1;
    aur_rx_d         = d;
    aur_rx_src_rdy_n = 1'b0;
    aur_rx_sof_n     = ~sof;
    aur_rx_eof_n     = ~eof;
    aur_rx_rem       = r;
    if (eof) eof_cyc = cyc;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    aur_rx_src_rdy_n = 1'b1;
    aur_rx_sof_n     = 1'b1;
    aur_rx_eof_n     = 1'b1;
  endtask

  // Halfword i of a packet carries seed+i; last_ctrl is the hand-derived ctrl.
  task automatic send_pkt(input int n, input bit r, input logic [15:0] seed,
                          input logic [7:0] last_ctrl, input bit push);
    logic [63:0] d;
    int nw;
    nw = (n + 3) / 4;
    if (push) begin
      for (int w = 0; w < nw; w++) begin
        d = '0;
        for (int j = 0; j < 4; j++)
          if (4*w + j < n) d[63-16*j -: 16] = seed + 16'(4*w + j);
        sb.push_back({(w == nw-1) ? last_ctrl : 8'h00, d});
      end
    end
    for (int i = 0; i < n; i++)
      hw(seed + 16'(i), i == 0, i == n-1, r);
    idle();
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
      sb.delete();
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pkt_rcvd"},    72'(n_rcvd), 72'(exp_rcvd));
    check({tag, "_pkt_dropped"}, 72'(n_drop), 72'(exp_drop));
    check({tag, "_pkt_err"},     72'(n_err),  72'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    aur_rx_d         = '0;
    aur_rx_src_rdy_n = 1'b1;
    aur_rx_sof_n     = 1'b1;
    aur_rx_eof_n     = 1'b1;
    aur_rx_rem       = 1'b0;
    out_rdy          = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_wr",   72'(out_wr),   72'd0);
    check("rst_out_data", 72'(out_data), 72'd0);
    check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    check("rst_pulses",   72'({pkt_rcvd, pkt_dropped, pkt_err}), 72'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // 1: 64-byte packet, 8 words, last ctrl 0x01, latency 2 after EOF
    lat_arm = 1'b1;
    send_pkt(32, 1'b1, 16'h1000, 8'h01, 1'b1);
    exp_rcvd++;
    wait_drain(100);
    check_counts("t1");
    check("t1_latency_seen", 72'(lat_arm), 72'd0);

    // 2: 61-byte (EOF lane 2, rem=0 -> 0x08) and 60-byte (EOF lane 1, rem=1 -> 0x10)
    send_pkt(31, 1'b0, 16'h2000, 8'h08, 1'b1);
    send_pkt(30, 1'b1, 16'h2100, 8'h10, 1'b1);
    exp_rcvd += 2;
    wait_drain(100);
    check_counts("t2");

    // 3: single-halfword packet
    sb.push_back({8'h80, 64'hABCD_0000_0000_0000});
    hw(16'hABCD, 1'b1, 1'b1, 1'b0);
    idle();
    exp_rcvd++;
    wait_drain(50);
    check_counts("t3");

    // 4: out_rdy low; two 200-word packets leave 112 free, so the third is dropped at SOF
    out_rdy = 1'b0;
    send_pkt(800, 1'b1, 16'h3000, 8'h01, 1'b1);
    send_pkt(800, 1'b1, 16'h4000, 8'h01, 1'b1);
    send_pkt(800, 1'b1, 16'h8000, 8'h01, 1'b0);
    exp_rcvd += 2;
    exp_drop += 1;
    repeat (4) @(posedge clk);
    check("t4_held_words", 72'(sb.size()), 72'd400);
    check_counts("t4_full");
    #1 out_rdy = 1'b1;
    wait_drain(1000);
    check_counts("t4");

    // 5: SOF mid-packet -> pkt_err, only the second packet (2 words) emerges
    for (int i = 0; i < 10; i++)
      hw(16'h5000 + 16'(i), i == 0, 1'b0, 1'b1);
    send_pkt(8, 1'b1, 16'h5100, 8'h01, 1'b1);
    exp_err++;
    exp_rcvd++;
    wait_drain(50);
    check_counts("t5");

    // 6: reset mid-packet, stray halfwords without SOF, then a 16-byte packet
    for (int i = 0; i < 5; i++)
      hw(16'h6000 + 16'(i), i == 0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset            = 1'b1;
    aur_rx_src_rdy_n = 1'b1;
    aur_rx_sof_n     = 1'b1;
    aur_rx_eof_n     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++)
      hw(16'h6100 + 16'(i), 1'b0, 1'b0, 1'b1);
    hw(16'h6104, 1'b0, 1'b1, 1'b1);
    idle();
    exp_err++;
    repeat (4) @(posedge clk);
    check("t6_no_stray_out", 72'(sb.size()), 72'd0);
    send_pkt(8, 1'b1, 16'h6200, 8'h01, 1'b1);
    exp_rcvd++;
    wait_drain(50);
    check_counts("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
